// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: component width, packed complex word and clamp limits.
// Used by the complex adder, the complex subtractor and the butterfly.
package fft_pkg;
    localparam int DATA_W = 8;
    localparam int CMAX   = (1 << (DATA_W - 1)) - 1;
    localparam int CMIN   = -(1 << (DATA_W - 1));

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    function automatic cplx_t cplx_make(input int re_v, input int im_v);
        cplx_t w;
        w.re = re_v[DATA_W-1:0];
        w.im = im_v[DATA_W-1:0];
        return w;
    endfunction
endpackage

// File: rtl/complex_sub_pipe_if.sv
// Stream bus of the complex subtractor: a/b in with valid/ready, diff out with valid/ready.
// CPLX_SUB_SATURATE_EN adds the ovf_flag output.
interface complex_sub_pipe_if #(
    parameter int DATA_W = fft_pkg::DATA_W
);
    logic                in_valid;
    logic                in_ready;
    logic [2*DATA_W-1:0] a;
    logic [2*DATA_W-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic [2*DATA_W-1:0] diff;
`ifdef CPLX_SUB_SATURATE_EN
    logic                ovf_flag;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, diff, ovf_flag);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, diff, ovf_flag);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, diff);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, diff);
`endif
endinterface

// File: rtl/complex_sub_core.sv
// One component of the complex subtractor: widened subtract, optional halving, limit to W bits.
// CPLX_SUB_SATURATE_EN selects clamping with an overflow output instead of wrap.
module complex_sub_core #(
    parameter int W     = fft_pkg::DATA_W,
    parameter int SCALE = 0
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   d_o,
    input  logic [W:0]   d_i,
`ifdef CPLX_SUB_SATURATE_EN
    output logic         ovf_o,
`endif
    output logic [W-1:0] y_o
);
    logic signed [W:0] sc;

    // One extra bit makes the raw difference exact for any pair of inputs.
    assign d_o = {a_i[W-1], a_i} - {b_i[W-1], b_i};

    generate
        if (SCALE != 0) begin : g_half
            assign sc = $signed(d_i) >>> 1;
        end else begin : g_full
            assign sc = $signed(d_i);
        end
    endgenerate

`ifdef CPLX_SUB_SATURATE_EN
    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    // Out of range exactly when the two top bits disagree; the sign picks the rail.
    assign ovf_o = sc[W] ^ sc[W-1];
    assign y_o   = ovf_o ? (sc[W] ? MIN_V : MAX_V) : sc[W-1:0];
`else
    logic unused_msb;
    assign unused_msb = sc[W];
    assign y_o        = sc[W-1:0];
`endif
endmodule

// File: rtl/complex_sub_pipe.sv
// Two-stage pipelined complex subtractor (diff = a - b) with valid/ready backpressure.
// Define CPLX_SUB_SATURATE_EN for clamping plus ovf_flag; default build wraps.
module complex_sub_pipe #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int SCALE  = 0
) (
    input logic               clk,
    input logic               rst,
    complex_sub_pipe_if.slave bus
);
    import fft_pkg::*;

    logic                   adv1;
    logic                   adv2;
    logic                   s1_valid_q;
    logic                   s1_valid_d;
    logic                   s2_valid_q;
    logic                   s2_valid_d;
    logic [1:0][DATA_W:0]   s1_q;
    logic [1:0][DATA_W:0]   s1_d;
    logic [1:0][DATA_W:0]   sub_d;
    logic [1:0][DATA_W-1:0] lim_y;
    logic [2*DATA_W-1:0]    diff_q;
    logic [2*DATA_W-1:0]    diff_d;
`ifdef CPLX_SUB_SATURATE_EN
    logic [1:0]             lim_ovf;
    logic                   ovf_q;
    logic                   ovf_d;
`endif

    // Index 1 is the real (upper) half of the packed word, index 0 the imaginary half.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_comp
            complex_sub_core #(
                .W     (DATA_W),
                .SCALE (SCALE)
            ) u_core (
                .a_i   (bus.a[gi*DATA_W +: DATA_W]),
                .b_i   (bus.b[gi*DATA_W +: DATA_W]),
                .d_o   (sub_d[gi]),
                .d_i   (s1_q[gi]),
`ifdef CPLX_SUB_SATURATE_EN
                .ovf_o (lim_ovf[gi]),
`endif
                .y_o   (lim_y[gi])
            );
        end
    endgenerate

    // A stage may load whenever it is empty or its contents leave this cycle.
    assign adv2 = !s2_valid_q || bus.out_ready;
    assign adv1 = !s1_valid_q || adv2;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
`ifdef CPLX_SUB_SATURATE_EN
        ovf_d      = ovf_q;
`endif
        if (adv1) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d = sub_d;
            end
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d = lim_y;
`ifdef CPLX_SUB_SATURATE_EN
                ovf_d  = |lim_ovf;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            diff_q     <= '0;
`ifdef CPLX_SUB_SATURATE_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            diff_q     <= diff_d;
`ifdef CPLX_SUB_SATURATE_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.diff      = diff_q;
`ifdef CPLX_SUB_SATURATE_EN
    assign bus.ovf_flag  = ovf_q && s2_valid_q;
`endif
endmodule
